dmem_byte_seq: RTL and testbench

Load/store sequencer directly upstream of the byte-banked data-memory interface. Accepts one core load/store request (byte, half or word, little-endian) and serialises it into single-byte accesses on that interface's `mem_addr` / `r_w` bus. For loads it collects the zero-extended byte returned on `mem_in[7:0]` after the bank read latency, assembles the result, applies sign or zero extension, and returns one response per request.

---
 rtl/dmem_byte_seq_pkg.sv | 31 +++
 rtl/dmem_load_ext.sv | 20 ++
 rtl/dmem_byte_seq.sv | 209 ++++++++++++++++++++
 tb/tb_dmem_byte_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_byte_seq_pkg.sv
// Shared encodings for the byte-serialising load/store sequencer.
package dmem_byte_seq_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

    // Index of the final byte of an access (N-1).
    function automatic logic [1:0] size_last(input logic [1:0] sz);
        case (sz)
            SZ_HALF: return 2'd1;
            SZ_WORD: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Sign/zero extension of an assembled load value according to access size.
module dmem_load_ext
    import dmem_byte_seq_pkg::*;
(
    input  logic [31:0] raw_data,
    input  logic [1:0]  size,
    input  logic        sext,
    output logic [31:0] ext_data
);

    always_comb begin
        ext_data = raw_data;
        case (size)
            SZ_BYTE: ext_data = {{24{sext & raw_data[7]}}, raw_data[7:0]};
            SZ_HALF: ext_data = {{16{sext & raw_data[15]}}, raw_data[15:0]};
            default: ext_data = raw_data;
        endcase
    end

endmodule

// File: rtl/dmem_byte_seq.sv
// Serialises byte/half/word loads and stores into single-byte bank accesses.
// Optional misalignment trap: define DMEM_MISALIGN_TRAP_EN.
//
// state    | meaning
// ST_IDLE  | ready for a request
// ST_ISSUE | drive byte address (and write data for stores)
// ST_WAIT  | hold read address until the bank returns the byte
// ST_DONE  | one-cycle response pulse
module dmem_byte_seq
    import dmem_byte_seq_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic        r_w,
    output logic [7:0]  mem_wdata,
    input  logic [31:0] mem_in
);

    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    localparam logic [1:0] WAIT_LOAD = 2'(LAT - 1);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  wait_q, wait_d;
    logic [31:0] data_q, data_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        r_w_q, r_w_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [1:0]  idx_nxt;
    logic [31:0] data_cap;
    logic [31:0] data_ext;
    logic        misalign;
    logic        unused_mem_in;

    assign unused_mem_in = ^mem_in[31:8];
    assign idx_nxt       = idx_q + 2'd1;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Assembled value including the byte arriving this cycle.
    always_comb begin
        data_cap = data_q;
        data_cap[{idx_q, 3'b000} +: 8] = mem_in[7:0];
    end

    dmem_load_ext u_load_ext (
        .raw_data (data_cap),
        .size     (size_q),
        .sext     (sext_q),
        .ext_data (data_ext)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        sext_d      = sext_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        idx_d       = idx_q;
        last_d      = last_q;
        wait_d      = wait_q;
        data_d      = data_q;
        mem_addr_d  = mem_addr_q;
        r_w_d       = r_w_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    sext_d  = req_sext;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    idx_d   = 2'd0;
                    last_d  = size_last(req_size);
                    data_d  = 32'd0;
                    if ((req_size == SZ_RSVD) || misalign) begin
                        state_d     = ST_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d    = ST_ISSUE;
                        mem_addr_d = req_addr;
                        r_w_d      = req_we;
                        if (req_we) begin
                            mem_wdata_d = req_wdata[7:0];
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    if (idx_q == last_q) begin
                        state_d     = ST_DONE;
                        r_w_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                    end else begin
                        idx_d       = idx_nxt;
                        mem_addr_d  = addr_q + {30'd0, idx_nxt};
                        mem_wdata_d = byte_sel(wdata_q, idx_nxt);
                    end
                end else begin
                    state_d = ST_WAIT;
                    wait_d  = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (wait_q == 2'd0) begin
                    data_d = data_cap;
                    if (idx_q == last_q) begin
                        state_d     = ST_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = data_ext;
                    end else begin
                        state_d    = ST_ISSUE;
                        idx_d      = idx_nxt;
                        mem_addr_d = addr_q + {30'd0, idx_nxt};
                    end
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            sext_q      <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            idx_q       <= 2'd0;
            last_q      <= 2'd0;
            wait_q      <= 2'd0;
            data_q      <= 32'd0;
            mem_addr_q  <= 32'd0;
            r_w_q       <= 1'b0;
            mem_wdata_q <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            wait_q      <= wait_d;
            data_q      <= data_d;
            mem_addr_q  <= mem_addr_d;
            r_w_q       <= r_w_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign r_w       = r_w_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_byte_seq.sv
// Scoreboard bench for dmem_byte_seq: byte-addressed memory model, random and directed requests.
module tb_dmem_byte_seq;
    import dmem_byte_seq_pkg::*;

    localparam int RD_LAT = 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_sext;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, r_w;
    logic [31:0] rsp_rdata, mem_addr, mem_in;
    logic [7:0]  mem_wdata;

    logic        r3_valid, r3_ready, r3_rsp_valid, r3_rsp_err, r3_r_w;
    logic [31:0] r3_rsp_rdata, r3_mem_addr, r3_mem_in;
    logic [7:0]  r3_mem_wdata;

    int          cyc;
    int          tests;
    int          fails;
    int          last_rsp_cyc;
    rsp_t        exp_rsp[$];
    wr_t         exp_wr[$];
    logic [7:0]  bank    [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] hist    [0:3];
    logic [31:0] hist3   [0:3];

    dmem_byte_seq #(.RD_LAT(RD_LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .r_w(r_w), .mem_wdata(mem_wdata), .mem_in(mem_in)
    );

    dmem_byte_seq #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(r3_valid), .req_ready(r3_ready), .req_we(1'b0),
        .req_size(SZ_WORD), .req_sext(1'b0), .req_addr(32'h0000_0040), .req_wdata(32'd0),
        .rsp_valid(r3_rsp_valid), .rsp_rdata(r3_rsp_rdata), .rsp_err(r3_rsp_err),
        .mem_addr(r3_mem_addr), .r_w(r3_r_w), .mem_wdata(r3_mem_wdata), .mem_in(r3_mem_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] bg(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] bank_rd(input logic [31:0] a);
        return bank.exists(a) ? bank[a] : bg(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : bg(a);
    endfunction

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        logic e;
        e = (sz == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
        e = e || (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a[1:0] != 2'b00);
`endif
        return e;
    endfunction

    // Little-endian gather of N bytes, then extension of the top byte's MSB.
    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_rd(a + 32'(k))) << (8 * k));
        if (n < 4 && sx && v[8 * n - 1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        bank[a]    = d;
        ref_mem[a] = d;
    endtask

    // Bank model: writes land at once, reads return the byte addressed RD_LAT cycles earlier.
    always @(negedge clk) begin
        if (r_w) bank[mem_addr] = mem_wdata;
        for (int j = 3; j > 0; j--) begin
            hist[j]  = hist[j - 1];
            hist3[j] = hist3[j - 1];
        end
        hist[0]   = mem_addr;
        hist3[0]  = r3_mem_addr;
        mem_in    = {24'hA5C3E1, bank_rd(hist[RD_LAT])};
        r3_mem_in = {24'h3C5A96, bg(hist3[3])};
    end

    always @(negedge clk) begin
        rsp_t e;
        wr_t  w;
        if (rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                check("unexpected_rsp", exp_rsp.size(), 1);
            end else begin
                e = exp_rsp.pop_front();
                check("rsp_cycle", cyc, e.cyc);
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
        if (r_w) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write", exp_wr.size(), 1);
            end else begin
                w = exp_wr.pop_front();
                check("wr_addr", mem_addr, w.a);
                check("wr_data", {24'd0, mem_wdata}, {24'd0, w.d});
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int max_wr, input bit want_rsp);
        int   n, guard, lat;
        logic err;
        rsp_t r;
        wr_t  w;
        req_we = we; req_size = sz; req_sext = sx; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("req_accept_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (last_rsp_cyc >= 0) check("b2b_accept_cycle", cyc, last_rsp_cyc + 1);
        n   = 1 << sz;
        err = model_err(sz, a);
        r.rdata = 32'd0;
        r.err   = err;
        if (err) begin
            lat = 1;
        end else if (we) begin
            lat = n + 1;
            for (int k = 0; k < n && k < max_wr; k++) begin
                w.a = a + 32'(k);
                w.d = wd[8 * k +: 8];
                exp_wr.push_back(w);
                ref_mem[w.a] = w.d;
            end
        end else begin
            lat = n * (RD_LAT + 1) + 1;
            r.rdata = model_load(a, sz, sx);
        end
        r.cyc = 32'(cyc + lat);
        if (want_rsp) begin
            exp_rsp.push_back(r);
            last_rsp_cyc = cyc + lat;
        end else begin
            last_rsp_cyc = -1;
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic rd_lat3_word;
        int a_cyc, guard;
        logic [31:0] exp;
        r3_valid = 1'b1;
        a_cyc = cyc;
        @(negedge clk);
        r3_valid = 1'b0;
        guard = 0;
        while (!r3_rsp_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        exp = {bg(32'h43), bg(32'h42), bg(32'h41), bg(32'h40)};
        check("lat3_rsp_valid", {31'd0, r3_rsp_valid}, 32'd1);
        check("lat3_rsp_cycle", cyc, a_cyc + 17);
        check("lat3_rsp_rdata", r3_rsp_rdata, exp);
    endtask

    task automatic abort_store;
        int guard;
        do_req(1'b1, SZ_WORD, 1'b0, 32'h0000_0200, 32'h5566_7788, 2, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check("abort_r_w", {31'd0, r_w}, 32'd0);
        guard = 0;
        while (guard < 6) begin
            @(negedge clk);
            guard++;
        end
    endtask

    initial begin
        logic [31:0] ra;
        int sel, guard;
        cyc = 0; tests = 0; fails = 0; last_rsp_cyc = -1;
        for (int j = 0; j < 4; j++) begin
            hist[j] = 32'd0;
            hist3[j] = 32'd0;
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_BYTE; req_sext = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; r3_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_r_w", {31'd0, r_w}, 32'd0);
        check("reset_mem_wdata", {24'd0, mem_wdata}, 32'd0);

        rd_lat3_word();

        do_req(1'b1, SZ_WORD, 1'b0, 32'h0000_0100, 32'hA1B2_C3D4, 4, 1'b1);
        preload(32'h0000_8000, 8'h80);
        do_req(1'b0, SZ_BYTE, 1'b1, 32'h0000_8000, 32'd0, 4, 1'b1);
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h0000_8000, 32'd0, 4, 1'b1);
        preload(32'hFFFF_FFFF, 8'h34);
        preload(32'h0000_0000, 8'h12);
        do_req(1'b0, SZ_HALF, 1'b0, 32'hFFFF_FFFF, 32'd0, 4, 1'b1);
        do_req(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'd0, 4, 1'b1);
        do_req(1'b1, 2'b11, 1'b0, 32'h0000_0100, 32'hFFFF_FFFF, 4, 1'b1);
        do_req(1'b1, SZ_WORD, 1'b0, 32'h0000_0102, 32'h1122_3344, 4, 1'b1);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'd0, 4, 1'b1);

        abort_store();

        for (int t = 0; t < 150; t++) begin
            sel = $urandom_range(0, 2);
            if (sel == 0)      ra = $urandom;
            else if (sel == 1) ra = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else               ra = 32'h0000_0100 + 32'($urandom_range(0, 63));
            sel = $urandom_range(0, 7);
            do_req(1'($urandom_range(0, 1)),
                   (sel < 2) ? SZ_BYTE : (sel < 4) ? SZ_HALF : (sel < 7) ? SZ_WORD : 2'b11,
                   1'($urandom_range(0, 1)), ra, $urandom, 4, 1'b1);
        end

        guard = 0;
        while ((exp_rsp.size() != 0 || exp_wr.size() != 0) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check("rsp_queue_drained", exp_rsp.size(), 0);
        check("wr_queue_drained", exp_wr.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
